fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WAIT_MAX, default 15, max cycles in REQ without IMEM_ACK before fault; legal 1..255.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 PC_O  in  12  next fetch address from PC stage.
REQ-005 PC_EN  out  1  advance PC stage one step (combinational).
REQ-006 REDIRECT  in  1  branch/jump taken; flush in-flight fetch.
REQ-007 IMEM_REQ  out  1  instruction-memory read request.
REQ-008 IMEM_ADDR  out  12  read address, registered.
REQ-009 IMEM_ACK  in  1  memory data valid this cycle.
REQ-010 IMEM_DATA  in  32  instruction word, sampled only when IMEM_ACK=1.
REQ-011 IR  out  32  instruction register to decoder.
REQ-012 IR_PC  out  12  address of instruction held in IR; drives PC stage PC_I.
REQ-013 IR_VALID  out  1  IR holds an unconsumed instruction.
REQ-014 DEC_READY  in  1  decoder accepts IR this cycle.
REQ-015 FETCH_ERR  out  1  sticky memory-timeout fault.
REQ-016 FETCH_CNT  out  16  count of instructions accepted by decoder.

Function
REQ-017 FSM states IDLE, REQ, HOLD, ERR; one-hot or binary, implementer's choice.
REQ-018 IDLE: at edge, IMEM_ADDR <= PC_O, wait counter <= 0, go REQ; IMEM_REQ=0 in IDLE.
REQ-019 REQ: IMEM_REQ=1, IMEM_ADDR held stable until ACK, REDIRECT or timeout.
REQ-020 REQ with IMEM_ACK=1 (same-cycle ACK legal): IR <= IMEM_DATA, IR_PC <= IMEM_ADDR, IR_VALID <= 1, go HOLD.
REQ-021 REQ without ACK: wait counter increments; when counter = WAIT_MAX-1 and no ACK, go ERR, FETCH_ERR <= 1.
REQ-022 HOLD: IR, IR_PC stable, IR_VALID=1; on DEC_READY=1: IR_VALID <= 0, FETCH_CNT <= FETCH_CNT+1, go IDLE.
REQ-023 PC_EN = (state==HOLD) & DEC_READY & ~REDIRECT; PC stage updates on same edge, IDLE samples new PC_O next edge.
REQ-024 Minimum issue rate one instruction per 3 cycles (IDLE, REQ with ACK, HOLD with ready).
REQ-025 REDIRECT=1 in REQ or HOLD: IR_VALID <= 0, go IDLE; ACK in same cycle discarded, IR unchanged; FETCH_CNT not incremented.
REQ-026 REDIRECT=1 in IDLE: no effect beyond normal IDLE->REQ (PC_O already holds target).
REQ-027 REDIRECT and DEC_READY together in HOLD: REDIRECT wins, PC_EN=0, no count.
REQ-028 ERR: IMEM_REQ=0, IR_VALID=0, PC_EN=0, FETCH_ERR=1; exit only by RST; inputs ignored.
REQ-029 FETCH_CNT wraps 16'hFFFF -> 16'h0000 with no flag.
REQ-030 IMEM_ACK outside REQ ignored.

Reset
REQ-031 RST=1 forces state IDLE immediately, independent of CLK.
REQ-032 Reset values: IMEM_ADDR=0, IR=32'h0, IR_PC=0, IR_VALID=0, FETCH_ERR=0, FETCH_CNT=0, wait counter=0; IMEM_REQ=0, PC_EN=0.
REQ-033 RST asserted mid-REQ drops IMEM_REQ same cycle; first request after release addresses PC_O sampled in IDLE.

Verification
REQ-034 Reset release, PC_O=0x000, ACK same cycle with 0x00500093, DEC_READY=1 -> IR=0x00500093, IR_PC=0x000, PC_EN pulse in HOLD, FETCH_CNT=1 after 3 cycles.
REQ-035 ACK delayed 4 cycles, WAIT_MAX=15 -> IMEM_REQ high 5 cycles, IMEM_ADDR constant, no FETCH_ERR.
REQ-036 No ACK, WAIT_MAX=15 -> FETCH_ERR=1 after 15 REQ cycles, IMEM_REQ=0, stays set until RST.
REQ-037 REDIRECT coincident with ACK (data 0xDEADBEEF), PC_O=0x040 -> IR unchanged, IR_VALID=0, next IMEM_ADDR=0x040.
REQ-038 DEC_READY=0 for 6 cycles in HOLD -> IR/IR_PC stable, PC_EN=0; then DEC_READY and REDIRECT together -> PC_EN=0, FETCH_CNT unchanged.
REQ-039 Preload 65535 accepted instructions, one more -> FETCH_CNT=0x0000.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch with redirect flush and
//            a sticky memory-timeout fault.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] pc_o_i,
    output logic        pc_en_o,
    input  logic        redirect_i,
    output logic        imem_req_o,
    output logic [11:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ir_o,
    output logic [11:0] ir_pc_o,
    output logic        ir_valid_o,
    input  logic        dec_ready_i,
    output logic        fetch_err_o,
    output logic [15:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q,     state_d;
    logic [11:0] imem_addr_q, imem_addr_d;
    logic [7:0]  wait_q,      wait_d;
    logic [31:0] ir_q,        ir_d;
    logic [11:0] ir_pc_q,     ir_pc_d;
    logic        ir_valid_q,  ir_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            imem_addr_q <= 12'h000;
            wait_q      <= 8'h00;
            ir_q        <= 32'h0000_0000;
            ir_pc_q     <= 12'h000;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            fetch_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            imem_addr_q <= imem_addr_d;
            wait_q      <= wait_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_addr_d = imem_addr_q;
        wait_d      = wait_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        fetch_err_d = fetch_err_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            S_IDLE: begin
                imem_addr_d = pc_o_i;
                wait_d      = 8'h00;
                state_d     = S_REQ;
            end
            S_REQ: begin
                // Redirect outranks a coincident ACK: the returned word is stale.
                if (redirect_i) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (imem_ack_i) begin
                    ir_d       = imem_data_i;
                    ir_pc_d    = imem_addr_q;
                    ir_valid_d = 1'b1;
                    state_d    = S_HOLD;
                end else if (wait_q == WAIT_LAST) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (dec_ready_i) begin
                    ir_valid_d  = 1'b0;
                    fetch_cnt_d = fetch_cnt_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            S_ERR: begin
                ir_valid_d  = 1'b0;
                fetch_err_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req_o  = (state_q == S_REQ);
    assign pc_en_o     = (state_q == S_HOLD) & dec_ready_i & ~redirect_i;
    assign imem_addr_o = imem_addr_q;
    assign ir_o        = ir_q;
    assign ir_pc_o     = ir_pc_q;
    assign ir_valid_o  = ir_valid_q;
    assign fetch_err_o = fetch_err_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule
`default_nettype wire
